hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/sb_entry.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the register hazard scoreboard: register-file
// geometry, the exception register and producer latencies, plus a small
// saturating-increment helper used by the stall performance counter.
package hazard_pkg;

   localparam int NUM_REGS    = 32;
   localparam int AW          = 5;
   localparam int MAX_LAT     = 34;
   localparam int EXC_REG     = 30;

   // Cycles from issue until a producer's result can be bypassed
   localparam int LAT_ALU     = 1;
   localparam int LAT_LW      = 2;
   localparam int LAT_MULTDIV = 34;

   // Width of one per-register latency counter
   localparam int LAT_W       = $clog2(MAX_LAT + 1);

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: a down-counter holding the number of cycles until
// the register's pending result becomes bypassable. A load overrides the
// per-cycle decrement. avail_o is high when the value is usable in the
// current cycle, which includes the cycle in which the count reaches zero.
module sb_entry
   import hazard_pkg::*;
#(
   parameter int W = LAT_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] cnt_o,
   output logic         avail_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and stop at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register, cleared asynchronously so a pending entry is discarded
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A count of one reaches zero at this edge, so the bypass already has it
   assign avail_o = (cnt_q <= W'(1));
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for the DX stage. Each architectural register
// has a latency counter; a DX instruction stalls while a source is not yet
// bypassable or while its write would retire ahead of an older, longer
// producer to the same register. Register 0 is never busy and the
// exception register is additionally loaded by exc_set.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = hazard_pkg::NUM_REGS,
   parameter int AW       = hazard_pkg::AW,
   parameter int MAX_LAT  = hazard_pkg::MAX_LAT,
   parameter int EXC_REG  = hazard_pkg::EXC_REG
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         dx_valid,
   input  logic [AW-1:0]                dx_rs_a,
   input  logic [AW-1:0]                dx_rs_b,
   input  logic [AW-1:0]                dx_rd,
   input  logic                         dx_we,
   input  logic [$clog2(MAX_LAT+1)-1:0] dx_lat,
   input  logic                         flush,
   input  logic                         exc_set,
   output logic                         stall,
   output logic                         ready_a,
   output logic                         ready_b,
   output logic [31:0]                  stall_cycles
);

   localparam int LW    = $clog2(MAX_LAT + 1);
   // Full address space so any source index reads a defined slot
   localparam int NSLOT = 1 << AW;

   // A simultaneous exc_set must still leave the exception register busy
   function automatic logic [LW-1:0] lat_floor1(input logic [LW-1:0] l);
      return (l == '0) ? LW'(1) : l;
   endfunction

   logic [LW-1:0] cnt   [NSLOT];
   logic          avail [NSLOT];

   logic          ready_a_raw;
   logic          ready_b_raw;
   logic          waw;
   logic          stall_raw;
   logic          issue;
   logic          issue_we;

   logic [31:0]   stall_cycles_q;
   logic [31:0]   stall_cycles_d;

   // Per-register slots; register 0 and addresses past NUM_REGS are constant idle
   for (genvar r = 0; r < NSLOT; r++) begin : g_slot
      if (r == 0 || r >= NUM_REGS) begin : g_idle
         assign cnt[r]   = '0;
         assign avail[r] = 1'b1;
      end else begin : g_entry
         logic          hit;
         logic          load_en;
         logic [LW-1:0] load_val;

         assign hit = issue_we && (dx_rd == AW'(r));

         if (r == EXC_REG) begin : g_exc
            assign load_en  = hit | exc_set;
            assign load_val = !exc_set ? dx_lat :
                              (hit ? lat_floor1(dx_lat) : LW'(1));
         end else begin : g_gpr
            assign load_en  = hit;
            assign load_val = dx_lat;
         end

         sb_entry #(
            .W       (LW)
         ) u_entry (
            .clk_i   (clock),
            .rst_i   (reset),
            .load_i  (load_en),
            .val_i   (load_val),
            .cnt_o   (cnt[r]),
            .avail_o (avail[r])
         );
      end
   end

   // Source readiness, write-after-write ordering and the resulting stall
   always_comb begin
      ready_a_raw = (dx_rs_a == '0) | avail[dx_rs_a];
      ready_b_raw = (dx_rs_b == '0) | avail[dx_rs_b];
      waw         = dx_we & (dx_rd != '0) & (dx_lat < cnt[dx_rd]);
      stall_raw   = dx_valid & ~flush & (~ready_a_raw | ~ready_b_raw | waw);
      issue       = dx_valid & ~stall_raw & ~flush;
      issue_we    = issue & dx_we & (dx_rd != '0);
   end

   // Outputs are forced to the idle view while reset is held
   assign stall   = stall_raw & ~reset;
   assign ready_a = ready_a_raw | reset;
   assign ready_b = ready_b_raw | reset;

   // Stall performance counter next value, saturating
   always_comb begin
      stall_cycles_d = stall_raw ? sat_inc32(stall_cycles_q) : stall_cycles_q;
   end

   // Stall performance counter register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table for the
// short-latency cases, then hand-written multdiv and reset sequences.
module tb_hazard_scoreboard;

   logic        clock;
   logic        reset;
   logic        dx_valid;
   logic [4:0]  dx_rs_a;
   logic [4:0]  dx_rs_b;
   logic [4:0]  dx_rd;
   logic        dx_we;
   logic [5:0]  dx_lat;
   logic        flush;
   logic        exc_set;
   logic        stall;
   logic        ready_a;
   logic        ready_b;
   logic [31:0] stall_cycles;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       v;
      logic [4:0] ra;
      logic [4:0] rb;
      logic [4:0] rd;
      logic       we;
      logic [5:0] lat;
      logic       fl;
      logic       ex;
      logic       s;
      logic       a;
      logic       b;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   hazard_scoreboard dut (
      .clock        (clock),
      .reset        (reset),
      .dx_valid     (dx_valid),
      .dx_rs_a      (dx_rs_a),
      .dx_rs_b      (dx_rs_b),
      .dx_rd        (dx_rd),
      .dx_we        (dx_we),
      .dx_lat       (dx_lat),
      .flush        (flush),
      .exc_set      (exc_set),
      .stall        (stall),
      .ready_a      (ready_a),
      .ready_b      (ready_b),
      .stall_cycles (stall_cycles)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                               input logic [4:0] rd, input logic we, input logic [5:0] lat,
                               input logic fl, input logic ex,
                               input logic s, input logic a, input logic b);
      vec_t t;
      t.v = v; t.ra = ra; t.rb = rb; t.rd = rd; t.we = we; t.lat = lat;
      t.fl = fl; t.ex = ex; t.s = s; t.a = a; t.b = b;
      return t;
   endfunction

   task automatic drive(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rd, input logic we, input logic [5:0] lat,
                        input logic fl, input logic ex);
      dx_valid = v; dx_rs_a = ra; dx_rs_b = rb; dx_rd = rd;
      dx_we = we; dx_lat = lat; flush = fl; exc_set = ex;
   endtask

   task automatic nop();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      int run;

      //          v   ra     rb     rd     we  lat    fl  ex   stall a  b
      tbl[0]  = mk(1, 5'd0,  5'd0,  5'd3,  1, 6'd2,  0,  0,   0, 1, 1); // lw r3
      tbl[1]  = mk(1, 5'd3,  5'd5,  5'd4,  1, 6'd1,  0,  0,   1, 0, 1); // add r4,r3,r5 stalls
      tbl[2]  = mk(1, 5'd3,  5'd5,  5'd4,  1, 6'd1,  0,  0,   0, 1, 1); // add issues
      tbl[3]  = mk(0, 5'd3,  5'd4,  5'd0,  0, 6'd0,  0,  0,   0, 1, 1); // r4 at cnt 1 is bypassable
      tbl[4]  = mk(1, 5'd0,  5'd0,  5'd6,  1, 6'd0,  0,  0,   0, 1, 1); // lat 0 issue to r6
      tbl[5]  = mk(1, 5'd6,  5'd4,  5'd6,  1, 6'd0,  0,  0,   0, 1, 1); // r6 never busy
      tbl[6]  = mk(1, 5'd0,  5'd0,  5'd3,  1, 6'd2,  0,  0,   0, 1, 1); // lw r3 again
      tbl[7]  = mk(1, 5'd3,  5'd0,  5'd8,  1, 6'd2,  1,  0,   0, 0, 1); // flushed dependent
      tbl[8]  = mk(1, 5'd3,  5'd8,  5'd0,  0, 6'd0,  0,  0,   0, 1, 1); // r3 counted on, r8 not issued
      tbl[9]  = mk(0, 5'd3,  5'd0,  5'd0,  0, 6'd0,  0,  0,   0, 1, 1);
      tbl[10] = mk(0, 5'd0,  5'd0,  5'd0,  0, 6'd0,  0,  1,   0, 1, 1); // exc_set pulse
      tbl[11] = mk(1, 5'd30, 5'd0,  5'd0,  0, 6'd0,  0,  0,   0, 1, 1); // bex sees r30 ready
      tbl[12] = mk(1, 5'd0,  5'd0,  5'd30, 1, 6'd2,  0,  1,   0, 1, 1); // setx lat 2 + exc_set
      tbl[13] = mk(1, 5'd30, 5'd0,  5'd0,  0, 6'd0,  0,  0,   1, 0, 1); // r30 holds 2
      tbl[14] = mk(1, 5'd30, 5'd0,  5'd0,  0, 6'd0,  0,  0,   0, 1, 1);
      tbl[15] = mk(1, 5'd0,  5'd0,  5'd30, 1, 6'd0,  0,  1,   0, 1, 1); // lat 0 + exc_set -> 1
      tbl[16] = mk(1, 5'd0,  5'd0,  5'd30, 1, 6'd0,  0,  0,   1, 1, 1); // waw 0 < 1
      tbl[17] = mk(0, 5'd30, 5'd0,  5'd0,  0, 6'd0,  0,  0,   0, 1, 1);

      // Reset view with a hazardous-looking DX held at the inputs
      reset = 1'b1;
      drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 6'd3, 1'b0, 1'b0);
      #2;
      chk("rst stall", {31'd0, stall}, 32'd0);
      chk("rst ready_a", {31'd0, ready_a}, 32'd1);
      chk("rst ready_b", {31'd0, ready_b}, 32'd1);
      chk("rst stall_cycles", stall_cycles, 32'd0);
      nop();
      @(negedge clock);
      reset = 1'b0;

      // Vector table, one row per cycle
      for (int i = 0; i < NV; i++) begin
         @(negedge clock);
         drive(tbl[i].v, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].we, tbl[i].lat, tbl[i].fl, tbl[i].ex);
         #1;
         chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, tbl[i].s});
         chk($sformatf("row%0d ready_a", i), {31'd0, ready_a}, {31'd0, tbl[i].a});
         chk($sformatf("row%0d ready_b", i), {31'd0, ready_b}, {31'd0, tbl[i].b});
      end
      @(negedge clock);
      nop();
      #1;
      chk("table stall_cycles", stall_cycles, 32'd3);

      // mul r7 then dependent sub r8,r7,r1: 33 stalls, ready on the 34th cycle
      @(negedge clock);
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 6'd34, 1'b0, 1'b0);
      @(negedge clock);
      drive(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 6'd1, 1'b0, 1'b0);
      run = 0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (!stall) break;
         run++;
         chk($sformatf("raw cyc%0d ready_a", i), {31'd0, ready_a}, 32'd0);
         @(negedge clock);
      end
      chk("raw run length", run, 32'd33);
      chk("raw ready_a rises", {31'd0, ready_a}, 32'd1);
      @(negedge clock);
      nop();
      #1;
      chk("raw stall_cycles", stall_cycles, 32'd36);

      // mul r7, independent add r9, then addi r7 waits for in-order writeback
      @(negedge clock);
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 6'd34, 1'b0, 1'b0);
      @(negedge clock);
      drive(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 6'd1, 1'b0, 1'b0);
      #1;
      chk("indep add stall", {31'd0, stall}, 32'd0);
      @(negedge clock);
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 6'd1, 1'b0, 1'b0);
      run = 0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (!stall) break;
         run++;
         @(negedge clock);
      end
      chk("waw run length", run, 32'd32);
      @(negedge clock);
      nop();
      #1;
      chk("waw stall_cycles", stall_cycles, 32'd68);

      // Reset while r7 still has 20 cycles to go
      @(negedge clock);
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 6'd34, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         @(negedge clock);
         nop();
      end
      @(negedge clock);
      drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 6'd1, 1'b0, 1'b0);
      #1;
      chk("pre-rst stall", {31'd0, stall}, 32'd1);
      chk("pre-rst ready_a", {31'd0, ready_a}, 32'd0);
      reset = 1'b1;
      #1;
      chk("async rst stall", {31'd0, stall}, 32'd0);
      chk("async rst ready_a", {31'd0, ready_a}, 32'd1);
      chk("async rst ready_b", {31'd0, ready_b}, 32'd1);
      chk("async rst stall_cycles", stall_cycles, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("post-rst stall", {31'd0, stall}, 32'd0);
      chk("post-rst ready_a", {31'd0, ready_a}, 32'd1);
      @(negedge clock);
      drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 6'd1, 1'b0, 1'b0);
      #1;
      chk("post-rst waw stall", {31'd0, stall}, 32'd0);
      chk("post-rst stall_cycles", stall_cycles, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
